// File: rtl/lisnoc_def.sv
// Shared lisnoc flit definitions: type codes, type-field position,
// and the output arbiter state encoding.
package lisnoc_def;

  localparam int FLIT_TYPE_W = 2;

  localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
  localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  // Type field occupies the top FLIT_TYPE_W bits of a flit
  function automatic int flit_type_lsb(input int fw);
    return fw - FLIT_TYPE_W;
  endfunction

  function automatic logic is_head(input logic [1:0] t);
    return (t == FLIT_TYPE_HEADER) || (t == FLIT_TYPE_SINGLE);
  endfunction

endpackage

// File: rtl/lisnoc_arb_rr.sv
// Round-robin arbiter: first requester at or after pointer wins,
// one-hot grant, purely combinational.
module lisnoc_arb_rr #(
  parameter  int ports = 5,
  localparam int ptr_w = (ports > 1) ? $clog2(ports) : 1
) (
  input  logic [ports-1:0] req,
  input  logic [ptr_w-1:0] pointer,
  output logic [ports-1:0] gnt
);

  function automatic int rot(input logic [ptr_w-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    return (s >= ports) ? s - ports : s;
  endfunction

  // Scan from farthest to nearest so the nearest requester wins
  always_comb begin
    gnt = '0;
    for (int i = ports - 1; i >= 0; i--) begin
      if (req[rot(pointer, i)]) begin
        gnt = '0;
        gnt[rot(pointer, i)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lisnoc_output_wormhole_arb.sv
// Wormhole output arbiter with one-flit output register.
// Optional packet counter: LISNOC_OUTPUT_ARB_STATS_EN.
module lisnoc_output_wormhole_arb
  import lisnoc_def::*;
#(
  parameter  int data_width = 32,
  parameter  int ports      = 5,
  localparam int flit_width = data_width + 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ports*flit_width-1:0] in_flit_i,
  input  logic [ports-1:0]            in_valid_i,
  output logic [ports-1:0]            in_ready_o,
  output logic [flit_width-1:0]       out_flit_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [ports-1:0]            lock_o
`ifdef LISNOC_OUTPUT_ARB_STATS_EN
  ,
  output logic [15:0]                 pkt_count_o
`endif
);

  localparam int ptr_w = (ports > 1) ? $clog2(ports) : 1;
  localparam int t_lsb = flit_type_lsb(flit_width);

  arb_state_t state_q, state_d;

  logic [ports-1:0]      lock_q, lock_d;
  logic [ports-1:0]      req, gnt, sel, xfer_v;
  logic [ptr_w-1:0]      ptr_q, ptr_d, xfer_idx;
  logic [flit_width-1:0] flit_q, xfer_flit;
  logic                  valid_q, can_acc, xfer;
  logic [1:0]            xfer_type;

  always_comb begin
    req = '0;
    for (int i = 0; i < ports; i++) begin
      req[i] = in_valid_i[i] &
        is_head(in_flit_i[i*flit_width+t_lsb +: FLIT_TYPE_W]);
    end
  end

  lisnoc_arb_rr #(
    .ports(ports)
  ) u_arb (
    .req    (req),
    .pointer(ptr_q),
    .gnt    (gnt)
  );

  assign can_acc = ~valid_q | out_ready_i;
  assign sel = (state_q == ARB_LOCKED) ? lock_q : gnt;
  // Gate with reset so nothing is accepted while reset is held
  assign in_ready_o = (rst & can_acc) ? sel : '0;
  assign xfer_v = in_valid_i & in_ready_o;
  assign xfer = |xfer_v;

  always_comb begin
    xfer_flit = '0;
    xfer_idx = '0;
    for (int i = 0; i < ports; i++) begin
      if (xfer_v[i]) begin
        xfer_flit = xfer_flit | in_flit_i[i*flit_width +: flit_width];
        xfer_idx = ptr_w'(i);
      end
    end
  end

  assign xfer_type = xfer_flit[t_lsb +: FLIT_TYPE_W];

  always_comb begin
    state_d = state_q;
    lock_d = lock_q;
    ptr_d = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (xfer) begin
          ptr_d = (int'(xfer_idx) == ports - 1) ?
            '0 : ptr_w'(int'(xfer_idx) + 1);
          if (xfer_type == FLIT_TYPE_HEADER) begin
            state_d = ARB_LOCKED;
            lock_d = xfer_v;
          end
        end
      end
      ARB_LOCKED: begin
        if (xfer && xfer_type == FLIT_TYPE_LAST) begin
          state_d = ARB_IDLE;
          lock_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        lock_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      lock_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      lock_q <= lock_d;
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_q <= '0;
      valid_q <= 1'b0;
    end else if (xfer) begin
      flit_q <= xfer_flit;
      valid_q <= 1'b1;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_flit_o = flit_q;
  assign out_valid_o = valid_q;
  assign lock_o = lock_q;

`ifdef LISNOC_OUTPUT_ARB_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == ARB_IDLE && xfer && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign pkt_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_lisnoc_output_wormhole_arb.sv
// Bench for lisnoc_output_wormhole_arb: directed scenarios plus
// random traffic against a packet-level reference model.
module tb_lisnoc_output_wormhole_arb;

  localparam int DW = 32;
  localparam int P = 5;
  localparam int FW = DW + 2;
  localparam int BD = 512;

  localparam logic [1:0] T_PAY = 2'b00;
  localparam logic [1:0] T_HDR = 2'b01;
  localparam logic [1:0] T_LST = 2'b10;
  localparam logic [1:0] T_SGL = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [P*FW-1:0] in_flit = '0;
  logic [P-1:0] in_valid = '0;
  logic [P-1:0] in_ready;
  logic [FW-1:0] out_flit;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [P-1:0] lock;
`ifdef LISNOC_OUTPUT_ARB_STATS_EN
  logic [15:0] pkt_count;
`endif

  lisnoc_output_wormhole_arb #(
    .data_width(DW),
    .ports(P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit_i  (in_flit),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_flit_o (out_flit),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .lock_o     (lock)
`ifdef LISNOC_OUTPUT_ARB_STATS_EN
    ,
    .pkt_count_o(pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner of the output (-1 = free), next-priority port,
  // and the single output slot.
  int m_lock;
  int m_ptr;
  bit m_ov;
  logic [FW-1:0] m_of;

  logic [FW-1:0] src[P][BD];
  int hd[P];
  int tl[P];
  logic [P-1:0] en;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t,
                                       input logic [DW-1:0] d);
    return {t, d};
  endfunction

  task automatic push(input int p, input logic [FW-1:0] f);
    src[p][tl[p]] = f;
    tl[p]++;
  endtask

  task automatic flush();
    for (int p = 0; p < P; p++) begin
      hd[p] = 0;
      tl[p] = 0;
    end
  endtask

  task automatic drive();
    for (int p = 0; p < P; p++) begin
      in_valid[p] = en[p] && (hd[p] < tl[p]);
      in_flit[p*FW +: FW] = (hd[p] < tl[p]) ? src[p][hd[p]] : '0;
    end
  endtask

  function automatic logic [P-1:0] exp_ready();
    logic [P-1:0] r;
    logic [1:0] t;
    int q;
    r = '0;
    if (m_ov && !out_ready) return r;
    if (m_lock >= 0) begin
      r[m_lock] = 1'b1;
      return r;
    end
    for (int k = 0; k < P; k++) begin
      q = (m_ptr + k) % P;
      t = in_flit[q*FW+DW +: 2];
      if (in_valid[q] && (t == T_HDR || t == T_SGL)) begin
        r[q] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic [P-1:0] exp_lock();
    logic [P-1:0] l;
    l = '0;
    if (m_lock >= 0) l[m_lock] = 1'b1;
    return l;
  endfunction

  task automatic step();
    logic [P-1:0] er;
    logic [FW-1:0] f;
    bit moved;
    drive();
    #1;
    er = exp_ready();
    chk("in_ready", 64'(in_ready), 64'(er));
    @(posedge clk);
    moved = 0;
    for (int p = 0; p < P; p++) begin
      if (in_valid[p] && er[p]) begin
        f = src[p][hd[p]];
        hd[p]++;
        moved = 1;
        m_of = f;
        m_ov = 1;
        if (m_lock < 0) begin
          m_ptr = (p + 1) % P;
          if (f[FW-1 -: 2] == T_HDR) m_lock = p;
        end else if (f[FW-1 -: 2] == T_LST) begin
          m_lock = -1;
        end
      end
    end
    if (!moved && out_ready) m_ov = 0;
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_flit", 64'(out_flit), 64'(m_of));
    chk("lock", 64'(lock), 64'(exp_lock()));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = '1;
    for (int p = 0; p < P; p++) in_flit[p*FW +: FW] = mk(T_HDR, DW'(p));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_flit", 64'(out_flit), 64'd0);
    chk("rst_lock", 64'(lock), 64'd0);
    flush();
    m_lock = -1;
    m_ptr = 0;
    m_ov = 0;
    m_of = '0;
    en = '0;
    in_valid = '0;
    rst = 1'b1;
  endtask

  initial begin
    logic [FW-1:0] held;
    flush();
    en = '0;
    do_reset();

    // Two SINGLEs from ports 0 and 2, then pointer sits at 3
    out_ready = 1'b1;
    push(0, mk(T_SGL, 32'hA0));
    push(2, mk(T_SGL, 32'hA2));
    en = 5'b00101;
    step();
    chk("sgl_p0", 64'(out_flit), 64'(mk(T_SGL, 32'hA0)));
    step();
    chk("sgl_p2", 64'(out_flit), 64'(mk(T_SGL, 32'hA2)));
    push(0, mk(T_SGL, 32'hB0));
    push(3, mk(T_SGL, 32'hB3));
    en = 5'b01001;
    step();
    chk("ptr_is_3", 64'(out_flit), 64'(mk(T_SGL, 32'hB3)));
    step();
    step();
    chk("drain_idle", 64'(out_valid), 64'd0);

    // Port 1 packet while port 3 waits with a HEADER
    do_reset();
    out_ready = 1'b1;
    push(1, mk(T_HDR, 32'h11));
    push(1, mk(T_PAY, 32'h12));
    push(1, mk(T_PAY, 32'h13));
    push(1, mk(T_LST, 32'h14));
    push(3, mk(T_HDR, 32'h31));
    push(3, mk(T_LST, 32'h32));
    en = 5'b01010;
    step();
    chk("wh_lock1", 64'(lock), 64'h02);
    step();
    chk("wh_pay1", 64'(out_flit), 64'(mk(T_PAY, 32'h12)));
    step();
    chk("wh_lock1b", 64'(lock), 64'h02);
    step();
    chk("wh_last1", 64'(out_flit), 64'(mk(T_LST, 32'h14)));
    step();
    chk("wh_hdr3", 64'(out_flit), 64'(mk(T_HDR, 32'h31)));
    chk("wh_lock3", 64'(lock), 64'h08);
    step();
    step();

    // Backpressure in the middle of a packet
    push(0, mk(T_HDR, 32'h51));
    push(0, mk(T_PAY, 32'h52));
    push(0, mk(T_PAY, 32'h53));
    push(0, mk(T_PAY, 32'h54));
    push(0, mk(T_LST, 32'h55));
    en = 5'b00001;
    out_ready = 1'b1;
    step();
    step();
    held = out_flit;
    out_ready = 1'b0;
    repeat (3) begin
      step();
      chk("bp_stable", 64'(out_flit), 64'(mk(T_PAY, 32'h52)));
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    chk("bp_held", 64'(held), 64'(mk(T_PAY, 32'h52)));
    out_ready = 1'b1;
    step();
    chk("bp_p53", 64'(out_flit), 64'(mk(T_PAY, 32'h53)));
    step();
    chk("bp_p54", 64'(out_flit), 64'(mk(T_PAY, 32'h54)));
    step();
    chk("bp_last", 64'(out_flit), 64'(mk(T_LST, 32'h55)));
    step();

    // Port 4 starts with PAYLOAD: never accepted; port 0 still served
    push(4, mk(T_PAY, 32'h44));
    push(0, mk(T_HDR, 32'h61));
    push(0, mk(T_LST, 32'h62));
    en = 5'b10001;
    step();
    chk("perr_hdr0", 64'(out_flit), 64'(mk(T_HDR, 32'h61)));
    repeat (4) begin
      step();
      chk("perr_stall4", 64'(in_ready[4]), 64'd0);
    end
    chk("perr_idle", 64'(out_valid), 64'd0);
    hd[4] = tl[4];

    // Reset in the middle of a packet
    push(2, mk(T_HDR, 32'h71));
    push(2, mk(T_PAY, 32'h72));
    push(2, mk(T_PAY, 32'h73));
    push(2, mk(T_LST, 32'h74));
    en = 5'b00100;
    step();
    step();
    do_reset();
    out_ready = 1'b1;
    step();
    chk("mid_rst_quiet", 64'(out_valid), 64'd0);
    chk("mid_rst_lock", 64'(lock), 64'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < P; p++) begin
        if (hd[p] == tl[p]) begin
          hd[p] = 0;
          tl[p] = 0;
          if ($urandom % 10 < 3) begin
            push(p, mk(T_SGL, $urandom));
          end else begin
            push(p, mk(T_HDR, $urandom));
            for (int k = $urandom % 4; k > 0; k--) push(p, mk(T_PAY, $urandom));
            push(p, mk(T_LST, $urandom));
          end
        end
        en[p] = ($urandom % 10) < 7;
      end
      out_ready = ($urandom % 10) < 7;
      step();
    end

`ifdef LISNOC_OUTPUT_ARB_STATS_EN
    do_reset();
    out_ready = 1'b1;
    en = 5'b00001;
    for (int c = 0; c < 70000; c++) begin
      flush();
      push(0, mk(T_SGL, DW'(c)));
      drive();
      @(posedge clk);
      #1;
    end
    chk("cnt_sat", 64'(pkt_count), 64'hFFFF);
    flush();
    m_ov = 1;
    m_of = out_flit;
    push(1, mk(T_HDR, 32'h81));
    push(1, mk(T_PAY, 32'h82));
    push(1, mk(T_LST, 32'h83));
    en = 5'b00010;
    in_valid = '0;
    step();
    step();
    do_reset();
    chk("cnt_rst", 64'(pkt_count), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lisnoc_output_wormhole_arb.md
LISNOC_OUTPUT_WORMHOLE_ARB -- requirements
Module: lisnoc_output_wormhole_arb

Interface
REQ-001 SHALL have parameter data_width, default 32, flit payload width; localparam flit_width = data_width+2.
REQ-002 SHALL have parameter ports, default 5, number of requesting input ports (N,E,S,W,local).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_flit_i  input  ports*flit_width  concatenated input flits, port i at bits [i*flit_width +: flit_width].
REQ-006 SHALL have port in_valid_i  input  ports  per-port flit valid.
REQ-007 SHALL have port in_ready_o  output  ports  per-port flit accepted.
REQ-008 SHALL have port out_flit_o  output  flit_width  registered output flit.
REQ-009 SHALL have port out_valid_o  output  1  output flit valid.
REQ-010 SHALL have port out_ready_i  input  1  downstream ready.
REQ-011 SHALL have port lock_o  output  ports  one-hot port currently holding the output; all zero when idle.

Function
REQ-012 SHALL treat flit bits [flit_width-1:flit_width-2] as type: 01 HEADER, 00 PAYLOAD, 10 LAST, 11 SINGLE.
REQ-013 SHALL run an FSM with states IDLE and LOCKED; reset state IDLE.
REQ-014 IDLE: SHALL grant one port among those with in_valid_i=1 and type HEADER or SINGLE, round-robin starting at priority pointer.
REQ-015 IDLE: SHALL never grant a port presenting PAYLOAD or LAST (protocol error; flit stalls, in_ready_o=0).
REQ-016 SHALL assert in_ready_o[i] only for the granted/locked port i, and only when out_valid_o=0 or out_ready_i=1; at most one bit set.
REQ-017 SHALL transfer an input flit when in_valid_i[i] & in_ready_o[i]; flit appears on out_flit_o with out_valid_o=1 the next cycle (latency 1).
REQ-018 SHALL clear out_valid_o when out_ready_i=1 and no new flit transfers the same cycle; SHALL hold out_flit_o/out_valid_o stable while out_valid_o=1 and out_ready_i=0.
REQ-019 HEADER transferred in IDLE: SHALL go LOCKED on that port, lock_o one-hot set next cycle.
REQ-020 SINGLE transferred in IDLE: SHALL stay IDLE.
REQ-021 LOCKED: SHALL consider only the locked port regardless of other requests; flit type not rechecked except LAST.
REQ-022 LAST transferred in LOCKED: SHALL return to IDLE next cycle, lock_o cleared.
REQ-023 On each HEADER or SINGLE transfer from port k, priority pointer SHALL become (k+1) mod ports; wrap from ports-1 to 0.
REQ-024 Back-to-back: a new packet SHALL be grantable in the cycle after LAST transfers (no bubble beyond the FSM return).
REQ-025 Combinational path in_valid_i -> in_ready_o allowed; no path in_* -> out_*.

Reset
REQ-026 While rst=0: out_valid_o=0, out_flit_o=0, lock_o=0, in_ready_o=0, state IDLE, pointer=0, counter=0.
REQ-027 Reset mid-packet SHALL drop the lock and any buffered flit; no flit emitted after release until a new HEADER/SINGLE is granted.

Configuration
REQ-028 Macro LISNOC_OUTPUT_ARB_STATS_EN defined: SHALL add output pkt_count_o (16 bits), incremented on each HEADER or SINGLE transfer, saturating at 16'hFFFF.
REQ-029 Macro undefined: pkt_count_o and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-030 Flit type codes and type-field position SHALL come from the shared lisnoc definitions package (lisnoc_def), not local literals.
REQ-031 Round-robin grant logic SHALL be a sub-module lisnoc_arb_rr (inputs req, pointer; output one-hot gnt), reusable by other router outputs.

Verification
REQ-032 Reset: hold rst=0 with all in_valid_i=1 -> all outputs 0, in_ready_o=0.
REQ-033 Ports 0 and 2 each present SINGLE with out_ready_i=1 continuously, pointer 0 -> port 0 flit out at cycle 1, port 2 at cycle 2, pointer 3.
REQ-034 Port 1 sends HEADER,PAYLOAD,PAYLOAD,LAST while port 3 holds HEADER valid -> four port-1 flits consecutive, lock_o=5'b00010; port 3 granted the cycle after LAST.
REQ-035 Backpressure: out_ready_i=0 for 3 cycles mid-packet -> out_flit_o stable, in_ready_o=0, no flit lost or duplicated.
REQ-036 Port 4 presents PAYLOAD while IDLE -> in_ready_o[4]=0 indefinitely; port 0 HEADER still granted.
REQ-037 STATS_EN: 70000 SINGLE flits -> pkt_count_o=16'hFFFF; assert rst=0 mid-packet -> lock_o=0, pkt_count_o=0.
